hex_display_arbiter: RTL and testbench

- Shares the board's six HEX digits between two requesters (req0 = CPU/debug, req1 = status/error).
- Grants ownership round-robin with a minimum hold time, so neither requester can starve the other.
- Latches the owner's 24-bit value and drives a nibble bus plus a per-digit blank mask; per-digit active-low segment decoders sit downstream.

---
 rtl/hex_display_arbiter_pkg.sv | 20 ++
 rtl/hex_display_arbiter_hold_timer.sv | 50 +++++
 rtl/hex_display_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// hex_display_arbiter_pkg
// Shared definitions for the HEX display arbiter slice:
//   - state encodings of the ownership FSM
//   - default digit count and the "all digits dark" mask
// Optional build macro used by the slice: HEX_DISP_LEADING_ZERO_BLANK_EN
// ---------------------------------------------------------------------------
package hex_display_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHOW0 = 2'd1;
  localparam state_t SHOW1 = 2'd2;

  localparam int DEF_NUM_DIGITS = 6;

  localparam logic [DEF_NUM_DIGITS-1:0] BLANK_ALL = 6'h3F;

endpackage

// File: rtl/hex_display_arbiter_hold_timer.sv
// ---------------------------------------------------------------------------
// hex_display_arbiter_hold_timer
// Minimum-hold timer for the display owner. Cleared on every grant, counts
// up once per cycle and saturates at HOLD_CYCLES; expired_o is high while
// the count sits at HOLD_CYCLES.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset (count returns to 0)
//   clear_i    restart the hold window (count := 0 on next edge)
//   expired_o  hold window has fully elapsed
//
// TIMER_W must satisfy 2**TIMER_W > HOLD_CYCLES, HOLD_CYCLES >= 1.
// ---------------------------------------------------------------------------
module hex_display_arbiter_hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int TIMER_W     = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] HoldLimit = TIMER_W'(HOLD_CYCLES);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Clear wins over counting so a grant always opens a full new window.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q != HoldLimit) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == HoldLimit);

endmodule

// File: rtl/hex_display_arbiter.sv
// ---------------------------------------------------------------------------
// hex_display_arbiter
// Shares the board's HEX digits between two valid/ready requesters
// (req0 = CPU/debug, req1 = status/error). Ownership is granted round-robin
// with a minimum hold time; the owner's value is latched onto a nibble bus
// together with a per-digit blank mask for the downstream segment decoders.
//
// Ports:
//   clk            system clock (single domain)
//   rst_n          asynchronous active-low reset; display goes dark at once
//   req0_valid/_data/_ready   requester 0 handshake and value
//   req1_valid/_data/_ready   requester 1 handshake and value
//   disp_nibbles   latched display value, nibble i drives digit i
//   disp_blank     per-digit blank, 1 = digit dark
//   owner          index of the current owner
//   owner_valid    0 until the first grant after reset
//
// Build option: HEX_DISP_LEADING_ZERO_BLANK_EN blanks digits above the
// highest nonzero nibble on each accepted value (digit 0 always lit).
// Without it every digit is lit once something has been accepted.
// ---------------------------------------------------------------------------
module hex_display_arbiter
  import hex_display_arbiter_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int TIMER_W     = 26
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0_valid,
  input  logic [4*NUM_DIGITS-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [4*NUM_DIGITS-1:0] req1_data,
  output logic                    req1_ready,
  output logic [4*NUM_DIGITS-1:0] disp_nibbles,
  output logic [NUM_DIGITS-1:0]   disp_blank,
  output logic                    owner,
  output logic                    owner_valid
);

  // The package mask covers the default digit count; other sizes fall back
  // to an all-ones mask of the configured width.
  localparam logic [NUM_DIGITS-1:0] ResetBlank =
      (NUM_DIGITS == DEF_NUM_DIGITS) ? NUM_DIGITS'(BLANK_ALL) : {NUM_DIGITS{1'b1}};

  state_t                  state_q, state_d;
  logic                    lastOwner_q, lastOwner_d;
  logic [4*NUM_DIGITS-1:0] dispNibbles_q, dispNibbles_d;
  logic [NUM_DIGITS-1:0]   dispBlank_q, dispBlank_d;
  logic                    owner_q, owner_d;
  logic                    ownerValid_q, ownerValid_d;

  logic                    holdExpired;
  logic                    accept0, accept1;
  logic                    take;
  logic                    takeIdx;
  logic                    grant;
  logic [4*NUM_DIGITS-1:0] selData;
  logic [NUM_DIGITS-1:0]   blankMask;

  hex_display_arbiter_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .TIMER_W     (TIMER_W)
  ) u_hold_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (grant),
    .expired_o (holdExpired)
  );

  // Readiness never looks at the port's own valid, only at the state, the
  // hold window and the competitor's valid. Once the hold has expired and
  // the other side is asking, the owner is held off so a same-cycle switch
  // cannot race an owner update.
  always_comb begin
    req0_ready = 1'b1;
    req1_ready = 1'b1;
    case (state_q)
      SHOW0: begin
        req0_ready = !(holdExpired && req1_valid);
        req1_ready = holdExpired;
      end
      SHOW1: begin
        req1_ready = !(holdExpired && req0_valid);
        req0_ready = holdExpired;
      end
      default: begin
        req0_ready = 1'b1;
        req1_ready = 1'b1;
      end
    endcase
  end

  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;

  // Pick the single transfer taken this cycle. In SHOWn the ready logic
  // already makes the two accepts mutually exclusive; only IDLE needs the
  // round-robin tie-break on lastOwner_q.
  always_comb begin
    take    = 1'b0;
    takeIdx = 1'b0;
    grant   = 1'b0;
    case (state_q)
      SHOW0: begin
        if (accept1) begin
          take    = 1'b1;
          takeIdx = 1'b1;
          grant   = 1'b1;
        end else if (accept0) begin
          take    = 1'b1;
          takeIdx = 1'b0;
        end
      end
      SHOW1: begin
        if (accept0) begin
          take    = 1'b1;
          takeIdx = 1'b0;
          grant   = 1'b1;
        end else if (accept1) begin
          take    = 1'b1;
          takeIdx = 1'b1;
        end
      end
      default: begin
        if (accept0 && accept1) begin
          take    = 1'b1;
          takeIdx = !lastOwner_q;
          grant   = 1'b1;
        end else if (accept0 || accept1) begin
          take    = 1'b1;
          takeIdx = accept1;
          grant   = 1'b1;
        end
      end
    endcase
  end

  assign selData = takeIdx ? req1_data : req0_data;

`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
  logic upperZero;

  // Walk from the top digit down; a digit is dark while every nibble at or
  // above it is zero. Digit 0 is excluded so a zero value still shows "0".
  always_comb begin
    blankMask = '0;
    upperZero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upperZero    = upperZero && (selData[4*i +: 4] == 4'h0);
      blankMask[i] = upperZero;
    end
  end
`else
  assign blankMask = '0;
`endif

  always_comb begin
    state_d       = state_q;
    lastOwner_d   = lastOwner_q;
    dispNibbles_d = dispNibbles_q;
    dispBlank_d   = dispBlank_q;
    owner_d       = owner_q;
    ownerValid_d  = ownerValid_q;
    if (take) begin
      state_d       = takeIdx ? SHOW1 : SHOW0;
      dispNibbles_d = selData;
      dispBlank_d   = blankMask;
      owner_d       = takeIdx;
      ownerValid_d  = 1'b1;
    end
    if (grant) begin
      lastOwner_d = takeIdx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lastOwner_q   <= 1'b1;
      dispNibbles_q <= '0;
      dispBlank_q   <= ResetBlank;
      owner_q       <= 1'b0;
      ownerValid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      lastOwner_q   <= lastOwner_d;
      dispNibbles_q <= dispNibbles_d;
      dispBlank_q   <= dispBlank_d;
      owner_q       <= owner_d;
      ownerValid_q  <= ownerValid_d;
    end
  end

  assign disp_nibbles = dispNibbles_q;
  assign disp_blank   = dispBlank_q;
  assign owner        = owner_q;
  assign owner_valid  = ownerValid_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hex_display_arbiter
// Directed bench for hex_display_arbiter with HOLD_CYCLES = 4. Honours the
// HEX_DISP_LEADING_ZERO_BLANK_EN build option for blank-mask expectations.
// ---------------------------------------------------------------------------
module tb_hex_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [23:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [23:0] req1_data;
  logic        req1_ready;
  logic [23:0] disp_nibbles;
  logic [5:0]  disp_blank;
  logic        owner;
  logic        owner_valid;

  int checkCount = 0;
  int passCount  = 0;

`ifdef HEX_DISP_LEADING_ZERO_BLANK_EN
  localparam logic [5:0] BlankBeef = 6'b110000;
  localparam logic [5:0] BlankC0   = 6'b111100;
  localparam logic [5:0] BlankFf   = 6'b111100;
  localparam logic [5:0] BlankZero = 6'b111110;
`else
  localparam logic [5:0] BlankBeef = 6'b000000;
  localparam logic [5:0] BlankC0   = 6'b000000;
  localparam logic [5:0] BlankFf   = 6'b000000;
  localparam logic [5:0] BlankZero = 6'b000000;
`endif

  hex_display_arbiter #(
    .NUM_DIGITS  (6),
    .HOLD_CYCLES (4),
    .TIMER_W     (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .disp_nibbles (disp_nibbles),
    .disp_blank   (disp_blank),
    .owner        (owner),
    .owner_valid  (owner_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v0, input logic [23:0] d0,
                               input logic v1, input logic [23:0] d1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_data  = '0;
    req1_valid = 1'b0;
    req1_data  = '0;
    #12;

    // Reset state
    checkOutput("rst_blank",       32'(disp_blank),   32'h3F);
    checkOutput("rst_nibbles",     32'(disp_nibbles), 32'h0);
    checkOutput("rst_owner",       32'(owner),        32'h0);
    checkOutput("rst_owner_valid", 32'(owner_valid),  32'h0);
    checkOutput("rst_ready0",      32'(req0_ready),   32'h1);
    checkOutput("rst_ready1",      32'(req1_ready),   32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both valid in IDLE: req0 wins the first tie
    applyStimulus(1'b1, 24'h123456, 1'b1, 24'h00BEEF);
    checkOutput("idle_ready0", 32'(req0_ready), 32'h1);
    checkOutput("idle_ready1", 32'(req1_ready), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h00BEEF);
    checkOutput("tie_nibbles",     32'(disp_nibbles), 32'h123456);
    checkOutput("tie_owner",       32'(owner),        32'h0);
    checkOutput("tie_owner_valid", 32'(owner_valid),  32'h1);
    checkOutput("tie_blank",       32'(disp_blank),   32'h0);
    checkOutput("hold_ready1_c0",  32'(req1_ready),   32'h0);
    for (int k = 1; k <= 3; k++) begin
      nextCycle();
      checkOutput($sformatf("hold_ready1_c%0d", k), 32'(req1_ready), 32'h0);
    end
    nextCycle();
    checkOutput("expired_ready1", 32'(req1_ready), 32'h1);
    checkOutput("expired_ready0", 32'(req0_ready), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("switch_owner",   32'(owner),        32'h1);
    checkOutput("switch_nibbles", 32'(disp_nibbles), 32'h00BEEF);
    checkOutput("switch_blank",   32'(disp_blank),   32'(BlankBeef));

    // Owner updates mid-hold do not restart the hold window
    doReset();
    applyStimulus(1'b1, 24'h111111, 1'b0, 24'h0);
    nextCycle();
    applyStimulus(1'b1, 24'h222222, 1'b1, 24'h0000C0);
    checkOutput("upd_first",  32'(disp_nibbles), 32'h111111);
    checkOutput("upd_ready0", 32'(req0_ready),   32'h1);
    checkOutput("upd_ready1", 32'(req1_ready),   32'h0);
    nextCycle();
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h0000C0);
    checkOutput("upd_second",      32'(disp_nibbles), 32'h222222);
    checkOutput("upd_owner",       32'(owner),        32'h0);
    checkOutput("upd_hold_c1",     32'(req1_ready),   32'h0);
    for (int k = 2; k <= 3; k++) begin
      nextCycle();
      checkOutput($sformatf("upd_hold_c%0d", k), 32'(req1_ready), 32'h0);
    end
    nextCycle();
    checkOutput("upd_expired_ready1", 32'(req1_ready), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("upd_switch_owner",   32'(owner),        32'h1);
    checkOutput("upd_switch_nibbles", 32'(disp_nibbles), 32'h0000C0);
    checkOutput("upd_switch_blank",   32'(disp_blank),   32'(BlankC0));

    // No contention after expiry: owner keeps writing
    doReset();
    applyStimulus(1'b1, 24'hABCDEF, 1'b0, 24'h0);
    nextCycle();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    for (int k = 1; k <= 4; k++) nextCycle();
    checkOutput("nocont_ready0", 32'(req0_ready), 32'h1);
    applyStimulus(1'b1, 24'h0000FF, 1'b0, 24'h0);
    nextCycle();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("nocont_nibbles", 32'(disp_nibbles), 32'h0000FF);
    checkOutput("nocont_owner",   32'(owner),        32'h0);
    checkOutput("nocont_blank",   32'(disp_blank),   32'(BlankFf));

    // Same-cycle conflict at expiry: switch wins, req0 then waits a full hold
    applyStimulus(1'b1, 24'h777777, 1'b1, 24'h000000);
    checkOutput("conf_ready0", 32'(req0_ready), 32'h0);
    checkOutput("conf_ready1", 32'(req1_ready), 32'h1);
    nextCycle();
    applyStimulus(1'b1, 24'h777777, 1'b0, 24'h0);
    checkOutput("conf_owner",    32'(owner),        32'h1);
    checkOutput("conf_nibbles",  32'(disp_nibbles), 32'h000000);
    checkOutput("conf_blank",    32'(disp_blank),   32'(BlankZero));
    checkOutput("conf_wait_c0",  32'(req0_ready),   32'h0);
    for (int k = 1; k <= 3; k++) begin
      nextCycle();
      checkOutput($sformatf("conf_wait_c%0d", k), 32'(req0_ready), 32'h0);
    end
    nextCycle();
    checkOutput("conf_expired_ready0", 32'(req0_ready), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 24'h0, 1'b0, 24'h0);
    checkOutput("conf_back_owner",   32'(owner),        32'h0);
    checkOutput("conf_back_nibbles", 32'(disp_nibbles), 32'h777777);

    // Asynchronous reset mid-hold, checked before any further clock edge
    nextCycle();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_blank",       32'(disp_blank),   32'h3F);
    checkOutput("async_nibbles",     32'(disp_nibbles), 32'h0);
    checkOutput("async_owner",       32'(owner),        32'h0);
    checkOutput("async_owner_valid", 32'(owner_valid),  32'h0);
    checkOutput("async_ready0",      32'(req0_ready),   32'h1);
    checkOutput("async_ready1",      32'(req1_ready),   32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
